// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory.
// Round-robin on ties, fixed access stretch of WAIT_CYCLES+1 cycles, one-cycle completion pulse.

module mem_arbiter_rsp (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [31:0] rdata_in,
  input  logic        err_in,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  // rdata/err are only non-zero alongside the ready pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ready <= set;
      rdata <= set ? rdata_in : '0;
      err   <= set & err_in;
    end
  end
endmodule

module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int NREQ = 2;
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic addr_ok(input logic [31:0] a);
    return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI) && (a[1:0] == 2'b00);
  endfunction

  logic [NREQ-1:0]        valid;
  req_t [NREQ-1:0]        req;
  logic                   gnt_sel;
  req_t                   cur;
  logic                   cur_legal;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   last_grant;
  logic                   gnt_q;
  logic                   wr_lat;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   rd_stb;
  logic                   wr_stb;

  logic                   done_set;
  logic                   rsp_sel;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic [NREQ-1:0]        rsp_rdy;
  logic [NREQ-1:0]        rsp_errs;
  logic [NREQ-1:0][31:0]  rsp_rdatas;

  assign valid  = {req1_valid, req0_valid};
  assign req[0] = {req0_wr, req0_addr, req0_wdata};
  assign req[1] = {req1_wr, req1_addr, req1_wdata};

  // On a tie the requester that lost last time wins
  always_comb begin
    gnt_sel = valid[1];
    if (&valid) gnt_sel = ~last_grant;
  end

  assign cur       = req[gnt_sel];
  assign cur_legal = addr_ok(cur.addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      wr_lat     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_stb     <= 1'b0;
      wr_stb     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|valid) begin
            gnt_q      <= gnt_sel;
            last_grant <= gnt_sel;
            wr_lat     <= cur.wr;
            if (cur_legal) begin
              state   <= ACCESS;
              cnt     <= WAIT_LD;
              addr_q  <= cur.addr;
              wdata_q <= cur.wdata;
              rd_stb  <= ~cur.wr;
              wr_stb  <= cur.wr && (WAIT_LD == 4'd0);
            end else begin
              state <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_stb  <= 1'b0;
            wr_stb  <= 1'b0;
          end else begin
            cnt    <= cnt - 4'd1;
            // write strobe only in the final access cycle
            wr_stb <= wr_lat && (cnt == 4'd1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is loaded into the response registers on the edge that enters DONE
  always_comb begin
    done_set  = 1'b0;
    rsp_sel   = gnt_q;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (|valid && !cur_legal) begin
          done_set = 1'b1;
          rsp_sel  = gnt_sel;
          rsp_err  = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          done_set  = 1'b1;
          rsp_rdata = wr_lat ? 32'h0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    mem_arbiter_rsp u_rsp (
      .clk      (clk),
      .rst      (rst),
      .set      (done_set && (int'(rsp_sel) == i)),
      .rdata_in (rsp_rdata),
      .err_in   (rsp_err),
      .ready    (rsp_rdy[i]),
      .rdata    (rsp_rdatas[i]),
      .err      (rsp_errs[i])
    );
  end

  assign req0_ready = rsp_rdy[0];
  assign req0_rdata = rsp_rdatas[0];
  assign req0_err   = rsp_errs[0];
  assign req1_ready = rsp_rdy[1];
  assign req1_rdata = rsp_rdatas[1];
  assign req1_err   = rsp_errs[1];

  // Strobes drop the moment reset asserts so an aborted write never lands
  assign mem_read  = rd_stb & rst;
  assign mem_write = wr_stb & rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Random + directed bench for mem_arbiter against a transaction-level model.
// A second instance with WAIT_CYCLES=0 covers the shortest access.

module tb_mem_arbiter;
  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          DEPTH = 64;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = BASE + 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v  = '0;
  logic [1:0]  wr = '0;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  rdy, err;
  logic [31:0] rdata [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  logic        b_v = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_rdy, b_err, b_rdy1, b_err1;
  logic [31:0] b_rdata, b_rdata1;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write, b_busy;

  logic [31:0] mem     [DEPTH];
  logic [31:0] m0      [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        inited = 1'b0;

  int nchk = 0;
  int nerr = 0;
  int last_grant = 1;

  mem_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_wr(wr[0]), .req0_addr(addr[0]), .req0_wdata(wdata[0]),
    .req0_ready(rdy[0]), .req0_rdata(rdata[0]), .req0_err(err[0]),
    .req1_valid(v[1]), .req1_wr(wr[1]), .req1_addr(addr[1]), .req1_wdata(wdata[1]),
    .req1_ready(rdy[1]), .req1_rdata(rdata[1]), .req1_err(err[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut_w0 (
    .clk(clk), .rst(rst),
    .req0_valid(b_v), .req0_wr(b_wr), .req0_addr(b_addr), .req0_wdata(b_wdata),
    .req0_ready(b_rdy), .req0_rdata(b_rdata), .req0_err(b_err),
    .req1_valid(1'b0), .req1_wr(1'b0), .req1_addr(32'h0), .req1_wdata(32'h0),
    .req1_ready(b_rdy1), .req1_rdata(b_rdata1), .req1_err(b_err1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[AW+1:2];
  endfunction

  // Data memories seen by the two instances (async read, write on clock edge)
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= init_val(i);
        m0[i]  <= '0;
      end
      inited <= 1'b1;
    end else begin
      if (mem_write && in_rng(mem_addr)) mem[widx(mem_addr)] <= mem_wdata;
      if (b_mem_write && in_rng(b_mem_addr)) m0[widx(b_mem_addr)] <= b_mem_wdata;
    end
  end
  assign mem_rdata   = in_rng(mem_addr) ? mem[widx(mem_addr)] : 32'h0;
  assign b_mem_rdata = in_rng(b_mem_addr) ? m0[widx(b_mem_addr)] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    v        = 2'($urandom);
    wr       = 2'($urandom);
    addr[0]  = $urandom;
    addr[1]  = $urandom;
    wdata[0] = $urandom;
    wdata[1] = $urandom;
  endtask

  task automatic idle(input int n);
    v = '0;
    for (int k = 0; k < n; k++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rdy", 32'(rdy), 32'd0);
      chk("idle_strobe", 32'({mem_read, mem_write}), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r == 7) return BASE - 32'(4 * $urandom_range(1, 4));
    else if (r == 8) return LIMIT + 32'(4 * $urandom_range(0, 3));
    else             return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
  endfunction

  // One arbitrated transaction, driven in an IDLE cycle; returns in the following IDLE cycle
  task automatic xact(input logic [1:0] vv, input logic [1:0] ww,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1);
    int g, lat;
    logic lg, ew, acc, hit;
    logic [31:0] ea, ed, erd;
    v = vv; wr = ww; addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    g = (vv == 2'b11) ? 1 - last_grant : (vv[1] ? 1 : 0);
    last_grant = g;
    ea  = (g == 1) ? a1 : a0;
    ed  = (g == 1) ? d1 : d0;
    ew  = ww[g];
    lg  = in_rng(ea) && (ea[1:0] == 2'b00);
    lat = lg ? W + 2 : 1;
    erd = (lg && !ew) ? ref_mem[widx(ea)] : 32'h0;
    for (int k = 1; k <= lat; k++) begin
      step();
      acc = lg && (k <= W + 1);
      chk("mem_read", 32'(mem_read), 32'(acc && !ew));
      chk("mem_write", 32'(mem_write), 32'(acc && ew && (k == W + 1)));
      chk("mem_addr", mem_addr, acc ? ea : 32'h0);
      chk("mem_wdata", mem_wdata, acc ? ed : 32'h0);
      chk("busy", 32'(busy), 32'd1);
      for (int i = 0; i < 2; i++) begin
        hit = (k == lat) && (i == g);
        chk($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(hit));
        chk($sformatf("rdata%0d", i), rdata[i], hit ? erd : 32'h0);
        chk($sformatf("err%0d", i), 32'(err[i]), 32'(hit && !lg));
      end
      if (k < lat) noise();
    end
    if (lg && ew) ref_mem[widx(ea)] = ed;
    step();
    chk("rdy_pulse", 32'(rdy), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
    v = 2'b01; wr = 2'b01; addr[0] = a; wdata[0] = d;
    for (int k = 1; k <= W + 1; k++) begin
      step();
      chk("ab_busy", 32'(busy), 32'd1);
      chk("ab_write_pre", 32'(mem_write), 32'(k == W + 1));
    end
    rst = 1'b0;
    v   = '0;
    #1;
    chk("ab_gated", 32'(mem_write), 32'd0);
    chk("ab_read", 32'(mem_read), 32'd0);
    step();
    chk("ab_rdy", 32'(rdy), 32'd0);
    chk("ab_busy_rst", 32'(busy), 32'd0);
    chk("ab_addr", mem_addr, 32'h0);
    rst = 1'b1;
    last_grant = 1;
  endtask

  task automatic w0_test();
    b_v = 1'b1; b_wr = 1'b1; b_addr = BASE + 32'd8; b_wdata = 32'h1234_5678;
    step();
    chk("w0_write", 32'(b_mem_write), 32'd1);
    chk("w0_waddr", b_mem_addr, BASE + 32'd8);
    chk("w0_wdata", b_mem_wdata, 32'h1234_5678);
    chk("w0_rdy_early", 32'(b_rdy), 32'd0);
    b_v = 1'b0;
    step();
    chk("w0_wrdy", 32'(b_rdy), 32'd1);
    chk("w0_werr", 32'(b_err), 32'd0);
    chk("w0_write_off", 32'(b_mem_write), 32'd0);
    chk("w0_busy", 32'(b_busy), 32'd1);
    b_v = 1'b1; b_wr = 1'b0;
    step();
    chk("w0_rdy_gap", 32'(b_rdy), 32'd0);
    step();
    chk("w0_read", 32'(b_mem_read), 32'd1);
    chk("w0_rdy_read_early", 32'(b_rdy), 32'd0);
    b_v = 1'b0;
    step();
    chk("w0_read_once", 32'(b_mem_read), 32'd0);
    chk("w0_rrdy", 32'(b_rdy), 32'd1);
    chk("w0_rdata", b_rdata, 32'h1234_5678);
    chk("w0_other", 32'({b_rdy1, b_err1}), 32'd0);
    chk("w0_other_rdata", b_rdata1, 32'h0);
    step();
    chk("w0_rdy_end", 32'(b_rdy), 32'd0);
    chk("w0_busy_end", 32'(b_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    v = 2'b11;
    repeat (3) step();
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata0", rdata[0], 32'h0);
    chk("rst_rdata1", rdata[1], 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b1;

    // Contention straight out of reset: req0, req1, req0, req1
    xact(2'b11, 2'b01, 32'd1100, 32'h1111_AAAA, 32'd1100, 32'h0);
    xact(2'b11, 2'b01, 32'd1104, 32'h2222_BBBB, 32'd1100, 32'h0);
    xact(2'b11, 2'b01, 32'd1104, 32'h3333_CCCC, 32'd1104, 32'h0);
    xact(2'b11, 2'b01, 32'd1108, 32'h4444_DDDD, 32'd1104, 32'h0);
    idle(2);

    xact(2'b01, 2'b01, 32'd1032, 32'hDEAD_BEEF, 32'h0, 32'h0);
    idle(1);
    xact(2'b10, 2'b00, 32'h0, 32'h0, 32'd1032, 32'h0);
    idle(1);

    xact(2'b01, 2'b00, 32'd1020, 32'h0, 32'h0, 32'h0);
    xact(2'b01, 2'b00, 32'd1280, 32'h0, 32'h0, 32'h0);
    xact(2'b01, 2'b00, 32'd1026, 32'h0, 32'h0, 32'h0);
    idle(1);

    abort_write(32'd1040, 32'h0BAD_F00D);
    idle(2);
    xact(2'b01, 2'b00, 32'd1040, 32'h0, 32'h0, 32'h0);

    repeat (200) begin
      idle($urandom_range(0, 2));
      xact(2'($urandom_range(1, 3)), 2'($urandom), rand_addr(), $urandom, rand_addr(), $urandom);
    end
    idle(1);

    w0_test();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
